// File: rtl/gaussian_5x5_filter_pkg.sv
// Shared constants and the separable [1 4 6 4 1] kernel helper for the 5x5 Gaussian stage.
package gaussian_5x5_filter_pkg;

  localparam int DEFAULT_WIDTH = 320;
  localparam int ACC_W         = 17;
  localparam int ROUND_C       = 128;
  localparam int SHIFT         = 8;
  localparam int KERN [5]      = '{1, 4, 6, 4, 1};

  typedef logic [ACC_W-1:0] acc_t;

  // Same 1-D kernel serves both the horizontal and the vertical pass.
  function automatic acc_t kern_sum(input acc_t t0, input acc_t t1, input acc_t t2,
                                    input acc_t t3, input acc_t t4);
    return t0 * acc_t'(KERN[0]) + t1 * acc_t'(KERN[1]) + t2 * acc_t'(KERN[2])
         + t3 * acc_t'(KERN[3]) + t4 * acc_t'(KERN[4]);
  endfunction

endpackage

// File: rtl/gaussian_5x5_filter_if.sv
// Pixel stream bundle: data/blanking/valid in, and the same format out.
interface gaussian_5x5_filter_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] din;
  logic              blanking_in;
  logic              validin;
  logic [DATA_W-1:0] dout;
  logic              blanking_out;
  logic              validout;

  modport master (output din, blanking_in, validin,
                  input  dout, blanking_out, validout);

  modport slave  (input  din, blanking_in, validin,
                  output dout, blanking_out, validout);

endinterface

// File: rtl/gaussian_5x5_filter_line_buffer_ram.sv
// Single-port line buffer, read-before-write: rdata shows the old word during a write.
module gaussian_5x5_filter_line_buffer_ram #(
  parameter int WIDTH  = 320,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WIDTH];

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/gaussian_5x5_filter.sv
// Streaming 5x5 Gaussian smoothing with four cascaded line buffers and a 4-stage pipeline.
module gaussian_5x5_filter
  import gaussian_5x5_filter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DATA_W = 8,
  parameter int LAT    = 4
) (
  input logic                  clock,
  input logic                  reset,
  gaussian_5x5_filter_if.slave px
);

  localparam int CW = $clog2(WIDTH);

  typedef logic [DATA_W-1:0] pix_t;

  logic [CW-1:0] col;
  logic [2:0]    row;
  logic          accept;
  pix_t          lb_rd [4];
  pix_t          lb_wr [4];
  pix_t          win [5][5];
  acc_t          hsum [5];
  acc_t          vsum;
  acc_t          rnd;
  pix_t          c2, c3;
  logic          v1, v2, v3;
  logic          f1, f2, f3;
  logic          r1, r2, r3;
  logic [LAT-1:0] blank_pipe;
  pix_t          dout_q;
  logic          validout_q;

  assign accept = px.validin && !px.blanking_in;

  // LB0 holds the previous row, LB3 the row four lines back.
  assign lb_wr[0] = px.din;
  assign lb_wr[1] = lb_rd[0];
  assign lb_wr[2] = lb_rd[1];
  assign lb_wr[3] = lb_rd[2];

  for (genvar i = 0; i < 4; i++) begin : g_lb
    gaussian_5x5_filter_line_buffer_ram #(
      .WIDTH  (WIDTH),
      .DATA_W (DATA_W),
      .AW     (CW)
    ) u_lb (
      .clock (clock),
      .we    (accept),
      .addr  (col),
      .wdata (lb_wr[i]),
      .rdata (lb_rd[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset || px.blanking_in) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        if (row != 3'd4) row <= row + 3'd1;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stage 1: window shift; row 0 is the oldest line, column 4 the newest pixel.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
      win[0][4] <= lb_rd[3];
      win[1][4] <= lb_rd[2];
      win[2][4] <= lb_rd[1];
      win[3][4] <= lb_rd[0];
      win[4][4] <= px.din;
    end
  end

  // Stages 2 and 3 run freely; the valid bits decide what gets used.
  always_ff @(posedge clock) begin
    for (int r = 0; r < 5; r++)
      hsum[r] <= kern_sum(acc_t'(win[r][0]), acc_t'(win[r][1]), acc_t'(win[r][2]),
                          acc_t'(win[r][3]), acc_t'(win[r][4]));
    c2   <= win[2][2];
    vsum <= kern_sum(hsum[0], hsum[1], hsum[2], hsum[3], hsum[4]);
    c3   <= c2;
  end

  assign rnd = vsum + acc_t'(ROUND_C);

  always_ff @(posedge clock) begin
    if (reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      f1         <= 1'b0;
      f2         <= 1'b0;
      f3         <= 1'b0;
      r1         <= 1'b0;
      r2         <= 1'b0;
      r3         <= 1'b0;
      blank_pipe <= '0;
      validout_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      v1         <= accept;
      f1         <= (row >= 3'd4) && (col >= CW'(4));
      r1         <= (row >= 3'd2) && (col >= CW'(2));
      v2         <= v1;
      f2         <= f1;
      r2         <= r1;
      v3         <= v2;
      f3         <= f2;
      r3         <= r2;
      blank_pipe <= {blank_pipe[LAT-2:0], px.blanking_in};
      validout_q <= v3;
      if (v3) dout_q <= f3 ? pix_t'(rnd >> SHIFT) : (r3 ? c3 : '0);
    end
  end

  assign px.dout         = dout_q;
  assign px.validout     = validout_q;
  assign px.blanking_out = blank_pipe[LAT-1];

endmodule

// File: tb/tb_gaussian_5x5_filter.sv
// Directed bench for gaussian_5x5_filter on an 8-pixel-wide image.
module tb_gaussian_5x5_filter;

  localparam int W = 8;
  // Impulse response for inputs (4..6, 4..7) with 255 at (2,2).
  localparam int IMP [3][4] = '{'{36, 24, 6, 0}, '{24, 16, 4, 0}, '{6, 4, 1, 0}};

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   out_q[$];
  int   out_cyc_q[$];

  gaussian_5x5_filter_if #(.DATA_W(8)) px();

  gaussian_5x5_filter #(.WIDTH(W), .DATA_W(8), .LAT(4)) dut (
    .clock (clock),
    .reset (reset),
    .px    (px)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (px.validout === 1'b1) begin
      out_q.push_back(int'(px.dout));
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pix_val(input int mode, input int val, input int r, input int c);
    if (mode == 1) return (r == 2 && c == 2) ? 255 : 0;
    return val;
  endfunction

  function automatic int exp_val(input int mode, input int val, input int r, input int c);
    if (mode == 1) return (r >= 4 && c >= 4) ? IMP[r-4][c-4] : 0;
    return (r >= 2 && c >= 2) ? val : 0;
  endfunction

  task automatic run_frame(input int sid, input int rows, input int mode, input int val,
                           input int gap);
    int exp_q[$];
    int in_q[$];
    int n;
    out_q.delete();
    out_cyc_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        @(posedge clock); #1;
        px.din     = 8'(pix_val(mode, val, r, c));
        px.validin = 1'b1;
        in_q.push_back(cyc);
        exp_q.push_back(exp_val(mode, val, r, c));
        for (int g = 0; g < gap; g++) begin
          @(posedge clock); #1;
          px.validin = 1'b0;
        end
      end
    end
    @(posedge clock); #1;
    px.validin = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check($sformatf("s%0d out count", sid), out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("s%0d pix r%0d c%0d", sid, i / W, i % W), out_q[i], exp_q[i]);
      check($sformatf("s%0d lat r%0d c%0d", sid, i / W, i % W), out_cyc_q[i] - in_q[i], 4);
    end
  endtask

  // Blanking sample arrives with validin=1 and must be dropped.
  task automatic blank_pulse();
    int bc;
    bit seen;
    seen = 1'b0;
    @(posedge clock); #1;
    out_q.delete();
    out_cyc_q.delete();
    px.blanking_in = 1'b1;
    px.validin     = 1'b1;
    px.din         = 8'hAA;
    bc = cyc;
    @(posedge clock); #1;
    px.blanking_in = 1'b0;
    px.validin     = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (px.blanking_out === 1'b1) seen = 1'b1;
    end
    check("blank rise delay", seen ? cyc - bc : -1, 4);
    @(negedge clock);
    check("blank fall", px.blanking_out, 0);
    repeat (3) @(negedge clock);
    check("blank sample dropped", out_q.size(), 0);
  endtask

  initial begin
    int pc;
    reset          = 1'b1;
    px.din         = '0;
    px.validin     = 1'b0;
    px.blanking_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset validout", px.validout, 0);
    check("reset dout", px.dout, 0);
    check("reset blanking_out", px.blanking_out, 0);

    run_frame(1, 6, 0, 100, 0);
    blank_pulse();
    run_frame(2, 7, 1, 0, 0);
    blank_pulse();
    run_frame(3, 5, 0, 255, 0);
    blank_pulse();
    run_frame(4, 7, 1, 0, 1);
    blank_pulse();
    run_frame(5, 6, 0, 200, 0);
    blank_pulse();
    run_frame(6, 5, 0, 100, 0);

    // Reset in the middle of row 4 with outputs still in flight.
    blank_pulse();
    for (int i = 0; i < 4 * W + 7; i++) begin
      @(posedge clock); #1;
      px.din     = 8'd100;
      px.validin = 1'b1;
    end
    @(posedge clock); #1;
    px.validin = 1'b0;
    reset      = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    out_q.delete();
    out_cyc_q.delete();
    @(negedge clock);
    check("mid reset validout", px.validout, 0);
    check("mid reset dout", px.dout, 0);
    check("mid reset blanking_out", px.blanking_out, 0);
    repeat (6) @(negedge clock);
    check("mid reset flushed", out_q.size(), 0);
    @(posedge clock); #1;
    px.din     = 8'd100;
    px.validin = 1'b1;
    pc = cyc;
    @(posedge clock); #1;
    px.validin = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("post reset count", out_q.size(), 1);
    if (out_q.size() > 0) begin
      check("post reset pix", out_q[0], 0);
      check("post reset lat", out_cyc_q[0] - pc, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
